// File: rtl/button_reader.sv
// Debounced push-button reader for active-low board pins.
// Emits clean levels plus press/release/long/repeat pulses.
module button_reader #(
  parameter int NUM_BTN         = 4,
  parameter int DEBOUNCE_CYCLES = 240000,
  parameter int LONG_CYCLES     = 12000000,
  parameter int REPEAT_CYCLES   = 3000000
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_BTN-1:0] btn_n,
  output logic [NUM_BTN-1:0] btn_level,
  output logic [NUM_BTN-1:0] btn_press,
  output logic [NUM_BTN-1:0] btn_release,
  output logic [NUM_BTN-1:0] btn_long,
  output logic [NUM_BTN-1:0] btn_repeat,
  output logic               any_event
);

  localparam int DW   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int HMAX = (LONG_CYCLES > REPEAT_CYCLES) ?
                        LONG_CYCLES : REPEAT_CYCLES;
  localparam int HW   = $clog2(HMAX + 1);
  localparam int REPT = (REPEAT_CYCLES > 0) ?
                        REPEAT_CYCLES - 1 : 0;

  localparam logic [DW-1:0] DB_LAST   = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [HW-1:0] LONG_LAST = HW'(LONG_CYCLES - 1);
  localparam logic [HW-1:0] REP_LAST  = HW'(REPT);
  localparam logic [HW-1:0] HOLD_SAT  = HW'(HMAX);

  typedef enum logic [1:0] {
    IDLE,
    PRESSED,
    HELD
  } state_t;

  logic [NUM_BTN-1:0] sync1;
  logic [NUM_BTN-1:0] sync2;
  logic [NUM_BTN-1:0] s;

  // Two-flop synchronizer; released (1) is the safe reset value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= '1;
      sync2 <= '1;
    end else begin
      sync1 <= btn_n;
      sync2 <= sync1;
    end
  end

  assign s = ~sync2;

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_ch
    logic [DW-1:0] db_cnt;
    logic          st;
    logic          flip;
    logic          rise;
    logic          fall;
    logic [HW-1:0] hold;
    state_t        state;
    logic          press_q;
    logic          release_q;
    logic          long_q;
    logic          repeat_q;

    // The stable state flips on the same edge its counter expires,
    // so the FSM sees the change without an extra cycle of delay.
    assign flip = (s[i] != st) && (db_cnt == DB_LAST);
    assign rise = flip && !st;
    assign fall = flip && st;

    // Debounce: count consecutive disagreeing samples.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        st     <= 1'b0;
        db_cnt <= '0;
      end else if (s[i] == st) begin
        db_cnt <= '0;
      end else if (flip) begin
        st     <= ~st;
        db_cnt <= '0;
      end else begin
        db_cnt <= db_cnt + DW'(1);
      end
    end

    // Channel FSM; release wins over any coincident terminal count.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        state     <= IDLE;
        hold      <= '0;
        press_q   <= 1'b0;
        release_q <= 1'b0;
        long_q    <= 1'b0;
        repeat_q  <= 1'b0;
      end else begin
        press_q   <= 1'b0;
        release_q <= 1'b0;
        long_q    <= 1'b0;
        repeat_q  <= 1'b0;
        unique case (state)
          IDLE: begin
            if (rise) begin
              press_q <= 1'b1;
              hold    <= '0;
              state   <= PRESSED;
            end
          end
          PRESSED: begin
            if (fall) begin
              release_q <= 1'b1;
              hold      <= '0;
              state     <= IDLE;
            end else if (hold == LONG_LAST) begin
              long_q <= 1'b1;
              hold   <= '0;
              state  <= HELD;
            end else if (hold != HOLD_SAT) begin
              hold <= hold + HW'(1);
            end
          end
          HELD: begin
            if (fall) begin
              release_q <= 1'b1;
              hold      <= '0;
              state     <= IDLE;
            end else if (REPEAT_CYCLES == 0) begin
              hold <= '0;
            end else if (hold == REP_LAST) begin
              repeat_q <= 1'b1;
              hold     <= '0;
            end else if (hold != HOLD_SAT) begin
              hold <= hold + HW'(1);
            end
          end
          default: begin
            hold  <= '0;
            state <= IDLE;
          end
        endcase
      end
    end

    assign btn_level[i]   = st;
    assign btn_press[i]   = press_q;
    assign btn_release[i] = release_q;
    assign btn_long[i]    = long_q;
    assign btn_repeat[i]  = repeat_q;
  end

  assign any_event = |{btn_press, btn_release, btn_long, btn_repeat};

endmodule

// File: tb/tb_button_reader.sv
// Randomized bench for button_reader with an event-time model.
// Directed phases pin the model with literal expectations.
module tb_button_reader;

  localparam int D = 4;
  localparam int L = 20;
  localparam int R = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] btn_n = 2'b11;
  logic [1:0] btn_level;
  logic [1:0] btn_press;
  logic [1:0] btn_release;
  logic [1:0] btn_long;
  logic [1:0] btn_repeat;
  logic       any_event;

  int n_checks = 0;
  int n_pass = 0;
  bit cmp_en = 1'b0;

  button_reader #(
    .NUM_BTN(2),
    .DEBOUNCE_CYCLES(D),
    .LONG_CYCLES(L),
    .REPEAT_CYCLES(R)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .btn_n(btn_n),
    .btn_level(btn_level),
    .btn_press(btn_press),
    .btn_release(btn_release),
    .btn_long(btn_long),
    .btn_repeat(btn_repeat),
    .any_event(any_event)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  // Model: a level flips once the last D synchronized samples all
  // disagree with it; hold events are timed from the press edge.
  logic [1:0]   m_p1;
  logic [1:0]   m_level;
  logic [1:0]   e_press;
  logic [1:0]   e_rel;
  logic [1:0]   e_long;
  logic [1:0]   e_rep;
  logic [D-1:0] m_win [2];
  int           m_pt [2];
  int           m_edge;
  int           held;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_p1    = 2'b11;
      m_level = '0;
      e_press = '0;
      e_rel   = '0;
      e_long  = '0;
      e_rep   = '0;
      m_edge  = 0;
      for (int c = 0; c < 2; c++) begin
        m_win[c] = '0;
        m_pt[c]  = 0;
      end
    end else begin
      m_edge++;
      e_press = '0;
      e_rel   = '0;
      e_long  = '0;
      e_rep   = '0;
      for (int c = 0; c < 2; c++) begin
        if (m_win[c] == {D{~m_level[c]}}) begin
          if (!m_level[c]) begin
            e_press[c] = 1'b1;
            m_pt[c]    = m_edge;
          end else begin
            e_rel[c] = 1'b1;
          end
          m_level[c] = ~m_level[c];
        end else if (m_level[c]) begin
          held = m_edge - m_pt[c];
          if (held == L) e_long[c] = 1'b1;
          else if (held > L && (held - L) % R == 0)
            e_rep[c] = 1'b1;
        end
        m_win[c] = {m_win[c][D-2:0], ~m_p1[c]};
      end
      m_p1 = btn_n;
    end
  end

  // Whole-output comparison every cycle, away from the active edge.
  always @(negedge clk) begin
    if (cmp_en)
      chk("cycle",
          {btn_level, btn_press, btn_release,
           btn_long, btn_repeat, any_event},
          {m_level, e_press, e_rel, e_long, e_rep,
           |{e_press, e_rel, e_long, e_rep}});
  end

  task automatic press(input logic [1:0] m);
    btn_n = btn_n & ~m;
    step(5);
    chk("lvl_early", btn_level & m, 2'b00);
    step(1);
    chk("lvl_rise", btn_level & m, m);
    chk("press", btn_press, m);
    chk("press_any", any_event, 1'b1);
  endtask

  // Release timed so the level falls f edges after the press edge.
  task automatic release_at(input logic [1:0] m, input int f);
    step(f - 6);
    btn_n = btn_n | m;
    step(5);
    chk("rel_early", btn_release, 2'b00);
    step(1);
    chk("release", btn_release, m);
    chk("rel_nolong", btn_long, 2'b00);
  endtask

  int run_left [2];

  initial begin
    step(2);
    cmp_en = 1'b1;
    chk("rst_out",
        {btn_level, btn_press, btn_release,
         btn_long, btn_repeat, any_event}, 0);
    rst_n = 1'b1;
    step(3);

    press(2'b01);
    chk("quiet_ch1", btn_level[1], 1'b0);
    step(1);
    chk("press_once", btn_press, 2'b00);
    step(18);
    chk("long_early", btn_long, 2'b00);
    step(1);
    chk("long", btn_long, 2'b01);
    for (int k = 0; k < 5; k++) begin
      step(8);
      chk("repeat", btn_repeat, 2'b01);
    end
    btn_n[0] = 1'b1;
    step(5);
    chk("rel_early", btn_release, 2'b00);
    step(1);
    chk("release_long", btn_release, 2'b01);
    step(12);

    for (int k = 0; k < 6; k++) begin
      btn_n[0] = ~btn_n[0];
      step(2);
    end
    step(8);
    chk("bounce_lvl", btn_level, 2'b00);

    press(2'b01);
    release_at(2'b01, 10);
    step(10);
    press(2'b01);
    release_at(2'b01, 19);
    step(10);
    press(2'b01);
    release_at(2'b01, 20);
    step(10);

    press(2'b11);
    step(1);
    chk("any_once", any_event, 1'b0);
    step(24);
    rst_n = 1'b0;
    #1;
    chk("rst_hold",
        {btn_level, btn_press, btn_release,
         btn_long, btn_repeat, any_event}, 0);
    step(3);
    chk("rst_norel", btn_release, 2'b00);
    rst_n = 1'b1;
    step(5);
    chk("rst_early", btn_press, 2'b00);
    step(1);
    chk("rst_press", btn_press, 2'b11);
    btn_n = 2'b11;
    step(12);

    run_left[0] = 0;
    run_left[1] = 0;
    for (int c = 0; c < 4000; c++) begin
      for (int ch = 0; ch < 2; ch++) begin
        if (run_left[ch] == 0) begin
          btn_n[ch] = ~btn_n[ch];
          case ($urandom_range(0, 2))
            0: run_left[ch] = $urandom_range(1, 4);
            1: run_left[ch] = $urandom_range(5, 12);
            default: run_left[ch] = $urandom_range(15, 70);
          endcase
        end else begin
          run_left[ch]--;
        end
      end
      rst_n = ($urandom_range(0, 799) != 0);
      step(1);
    end
    rst_n = 1'b1;
    step(2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
